// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and default bit period
package uart_pkg;
  localparam int DEFAULT_DELAY_COUNTS = 22;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter flagging mid-bit and end-of-bit
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int DELAY_COUNTS = DEFAULT_DELAY_COUNTS
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic end_bit,
  output logic end_half
);
  localparam int W = $clog2(DELAY_COUNTS);
  localparam logic [W-1:0] HALF = W'((DELAY_COUNTS - 1) / 2);
  localparam logic [W-1:0] LAST = W'(DELAY_COUNTS - 1);
  logic [W-1:0] count;
  // free-running within a frame, wrapping once per bit period
  always_ff @(posedge clk)
    if (!rst || clear) count <= '0;
    else if (enable) count <= end_bit ? '0 : count + 1'b1;
  assign end_half = count == HALF;
  assign end_bit  = count == LAST;
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: serial receive controller delivering framed words with valid/error strobes
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DELAY_COUNTS = DEFAULT_DELAY_COUNTS,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS);
  rx_state_t state, state_nx;
  logic rx_s1, rx_s, end_bit, end_half, done, bad;
  logic [IW-1:0] idx;
  logic [DATA_BITS-1:0] shift;
  assign busy = state != IDLE;
  // two-flop synchroniser, preset to the idle-high line level
  always_ff @(posedge clk)
    if (!rst) {rx_s1, rx_s} <= 2'b11;
    else {rx_s1, rx_s} <= {rx, rx_s1};
  uart_baud_cnt #(.DELAY_COUNTS(DELAY_COUNTS)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .enable  (busy),
    .clear   (!busy),
    .end_bit (end_bit),
    .end_half(end_half)
  );
  // state register
  always_ff @(posedge clk)
    state <= !rst ? IDLE : state_nx;
  // next state; STOP leaves half a bit early so a back-to-back start edge is caught
  always_comb begin
    state_nx = state;
    done     = 1'b0;
    bad      = 1'b0;
    case (state)
      IDLE:    state_nx = rx_s ? IDLE : START;
      START:   state_nx = (end_half && rx_s) ? IDLE : end_bit ? DATA : START;
      DATA:    state_nx = (end_bit && idx == LAST_IDX) ? STOP : DATA;
      STOP: begin
        done     = end_half && rx_s;
        bad      = end_half && !rx_s;
        state_nx = done ? IDLE : bad ? BREAK : STOP;
      end
      BREAK:   state_nx = rx_s ? IDLE : BREAK;
      default: state_nx = IDLE;
    endcase
  end
  // mid-bit sampling into an LSB-first shift register and registered strobes
  always_ff @(posedge clk)
    if (!rst) begin
      idx       <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= done;
      frame_err <= bad;
      if (done) rx_data <= shift;
      if (state == START) idx <= '0;
      else if (state == DATA && end_half) begin
        shift <= {rx_s, shift[DATA_BITS-1:1]};
        idx   <= idx + 1'b1;
      end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed scoreboard bench for uart_rx_ctrl at two configurations
module tb_uart_rx_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic [7:0] rx_data_a;
  logic [6:0] rx_data_b;
  logic rx_valid_a, frame_err_a, busy_a, rx_valid_b, frame_err_b, busy_b;
  int n_cmp = 0, n_err = 0;
  int n_valid_a = 0, n_ferr_a = 0, n_valid_b = 0, n_ferr_b = 0;
  logic pv_a = 1'b0, pe_a = 1'b0, pv_b = 1'b0;
  logic [8:0] q_a[$], q_b[$];
  logic [8:0] exp_w;
  always #5 clk = ~clk;
  uart_rx_ctrl #(.DELAY_COUNTS(22), .DATA_BITS(8)) dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .rx_data(rx_data_a),
    .rx_valid(rx_valid_a), .frame_err(frame_err_a), .busy(busy_a)
  );
  uart_rx_ctrl #(.DELAY_COUNTS(4), .DATA_BITS(7)) dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .rx_data(rx_data_b),
    .rx_valid(rx_valid_b), .frame_err(frame_err_b), .busy(busy_b)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // drives one frame cycle by cycle; rst_at >= 0 pulses reset low at that cycle
  task automatic drive(input bit w, input int dc, input int nb, input logic [8:0] d,
                       input logic stop, input int rst_at);
    logic lvl;
    for (int c = 0; c < (nb + 2) * dc; c++) begin
      lvl = (c / dc == 0) ? 1'b0 : (c / dc <= nb) ? d[c / dc - 1] : stop;
      if (w) rx_b = lvl;
      else rx_a = lvl;
      rst = (c == rst_at) ? 1'b0 : 1'b1;
      cycles(1);
      if (c == rst_at) begin
        check("rst_rx_data", rx_data_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_valid", rx_valid_a, 0);
        check("rst_ferr", frame_err_a, 0);
      end
    end
    rst = 1'b1;
  endtask
  // output monitor: pops expected words on each valid strobe
  always @(negedge clk) begin
    if (rx_valid_a) begin
      n_valid_a++;
      check("a_busy_at_valid", busy_a, 0);
      check("a_valid_width", pv_a, 0);
      check("a_valid_err_excl", frame_err_a, 0);
      check("a_q_depth", q_a.size(), 1);
      if (q_a.size() > 0) begin
        exp_w = q_a.pop_front();
        check("a_rx_data", rx_data_a, exp_w);
      end
    end
    if (frame_err_a) begin
      n_ferr_a++;
      check("a_err_width", pe_a, 0);
    end
    if (rx_valid_b) begin
      n_valid_b++;
      check("b_valid_width", pv_b, 0);
      check("b_q_depth", q_b.size(), 1);
      if (q_b.size() > 0) begin
        exp_w = q_b.pop_front();
        check("b_rx_data", rx_data_b, exp_w);
      end
    end
    if (frame_err_b) n_ferr_b++;
    pv_a = rx_valid_a;
    pe_a = frame_err_a;
    pv_b = rx_valid_b;
  end
  initial begin
    cycles(3);
    check("reset_rx_data_a", rx_data_a, 0);
    check("reset_valid_a", rx_valid_a, 0);
    check("reset_ferr_a", frame_err_a, 0);
    check("reset_busy_a", busy_a, 0);
    check("reset_rx_data_b", rx_data_b, 0);
    check("reset_busy_b", busy_b, 0);
    rst = 1'b1;
    cycles(5);
    q_a.push_back(9'h0A5);
    drive(1'b0, 22, 8, 9'h0A5, 1'b1, -1);
    cycles(5);
    check("a5_valid_count", n_valid_a, 1);
    check("a5_ferr_count", n_ferr_a, 0);
    rx_a = 1'b0;
    cycles(5);
    rx_a = 1'b1;
    cycles(1);
    check("glitch_busy_high", busy_a, 1);
    cycles(30);
    check("glitch_busy_low", busy_a, 0);
    check("glitch_valid_count", n_valid_a, 1);
    check("glitch_ferr_count", n_ferr_a, 0);
    check("glitch_rx_data", rx_data_a, 8'hA5);
    drive(1'b0, 22, 8, 9'h03C, 1'b0, -1);
    cycles(100);
    check("break_ferr_count", n_ferr_a, 1);
    check("break_busy_held", busy_a, 1);
    check("break_rx_data", rx_data_a, 8'hA5);
    rx_a = 1'b1;
    cycles(30);
    check("break_busy_low", busy_a, 0);
    check("break_ferr_once", n_ferr_a, 1);
    check("break_no_frame", n_valid_a, 1);
    q_a.push_back(9'h000);
    drive(1'b0, 22, 8, 9'h000, 1'b1, -1);
    q_a.push_back(9'h0FF);
    drive(1'b0, 22, 8, 9'h0FF, 1'b1, -1);
    cycles(5);
    check("b2b_valid_count", n_valid_a, 3);
    check("b2b_rx_data", rx_data_a, 8'hFF);
    drive(1'b0, 22, 8, 9'h0F3, 1'b1, (1 + 4) * 22 + 11);
    cycles(30);
    check("abort_valid_count", n_valid_a, 3);
    check("abort_ferr_count", n_ferr_a, 1);
    check("abort_rx_data", rx_data_a, 0);
    q_a.push_back(9'h05A);
    drive(1'b0, 22, 8, 9'h05A, 1'b1, -1);
    cycles(5);
    check("5a_valid_count", n_valid_a, 4);
    check("5a_rx_data", rx_data_a, 8'h5A);
    q_b.push_back(9'h055);
    drive(1'b1, 4, 7, 9'h055, 1'b1, -1);
    cycles(5);
    check("b_valid_count", n_valid_b, 1);
    check("b_ferr_count", n_ferr_b, 0);
    check("b_rx_data_hold", rx_data_b, 7'h55);
    check("b_busy_idle", busy_b, 0);
    check("a_q_empty", q_a.size(), 0);
    check("b_q_empty", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
